// File: rtl/nco_phase_acc.sv
// Phase accumulator for a sine-LUT NCO with a one-deep FCW holding register.
// Optional LFSR phase dither on the LUT address: define NCO_PHASE_DITHER_EN.
module nco_phase_acc #(
    parameter int ACC_WIDTH = 32,
    parameter int PHI_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [ACC_WIDTH-1:0] fcw_data,
    input  logic                 fcw_valid,
    output logic                 fcw_ready,
    input  logic                 phase_clr,
    output logic [PHI_WIDTH-1:0] phi,
    output logic                 phi_valid,
    output logic                 wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] fcw_active_q, fcw_active_d;
    logic [ACC_WIDTH-1:0] fcw_pend_q, fcw_pend_d;
    logic [PHI_WIDTH-1:0] phi_q, phi_d;
    logic                 phi_valid_q, phi_valid_d;
    logic                 wrap_q, wrap_d;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 transfer;

`ifdef NCO_PHASE_DITHER_EN
    localparam int FRAC_W = ACC_WIDTH - PHI_WIDTH;

    logic [15:0]          lfsr_q, lfsr_d;
    logic [ACC_WIDTH-1:0] dither;
    logic [ACC_WIDTH-1:0] phase_src;

    function automatic logic [ACC_WIDTH-1:0] dither_add(input logic [ACC_WIDTH-1:0] a,
                                                        input logic [ACC_WIDTH-1:0] d);
        return a + d;
    endfunction

    // Dither is confined to the fraction bits below the LUT address.
    if (FRAC_W >= 16) begin : g_dith_ext
        assign dither = ACC_WIDTH'(lfsr_q);
    end else begin : g_dith_trunc
        assign dither = ACC_WIDTH'(lfsr_q[FRAC_W-1:0]);
    end
`endif

    assign fcw_ready = (state_q == IDLE) && !rst;
    assign transfer  = fcw_valid && fcw_ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fcw_active_d = fcw_active_q;
        fcw_pend_d   = fcw_pend_q;
        phi_d        = phi_q;
        phi_valid_d  = sample_en;
        wrap_d       = 1'b0;
        acc_sum      = {1'b0, acc_q} + {1'b0, fcw_active_q};
`ifdef NCO_PHASE_DITHER_EN
        lfsr_d       = lfsr_q;
        phase_src    = '0;
`endif

        if (sample_en) begin
            if (phase_clr) begin
                acc_d = '0;
            end else begin
                acc_d  = acc_sum[ACC_WIDTH-1:0];
                wrap_d = acc_sum[ACC_WIDTH];
            end
`ifdef NCO_PHASE_DITHER_EN
            phase_src = dither_add(acc_d, dither);
            phi_d     = phase_clr ? '0 : phase_src[ACC_WIDTH-1 -: PHI_WIDTH];
            lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`else
            phi_d     = acc_d[ACC_WIDTH-1 -: PHI_WIDTH];
`endif
        end

        // The pending word is promoted on the same strobe that still uses the old one.
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    fcw_pend_d = fcw_data;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (sample_en) begin
                    fcw_active_d = fcw_pend_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            fcw_active_q <= '0;
            fcw_pend_q   <= '0;
            phi_q        <= '0;
            phi_valid_q  <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fcw_active_q <= fcw_active_d;
            fcw_pend_q   <= fcw_pend_d;
            phi_q        <= phi_d;
            phi_valid_q  <= phi_valid_d;
            wrap_q       <= wrap_d;
        end
    end

`ifdef NCO_PHASE_DITHER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`endif

    assign phi       = phi_q;
    assign phi_valid = phi_valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Randomised self-checking bench for nco_phase_acc against a behavioural phase model.
module tb_nco_phase_acc;
    localparam int AW = 32;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_en;
    logic          phase_clr;
    logic          fcw_valid;
    logic [AW-1:0] fcw_data;
    logic          fcw_ready;
    logic [PW-1:0] phi;
    logic          phi_valid;
    logic          wrap;

    int errors = 0;
    int checks = 0;

    // Behavioural reference state
    logic [31:0] m_acc, m_active, m_pend;
    bit          m_busy;
    logic [7:0]  m_phi;
    bit          m_pv, m_wrap;
    logic [15:0] m_lfsr;

    nco_phase_acc #(.ACC_WIDTH(AW), .PHI_WIDTH(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .fcw_data  (fcw_data),
        .fcw_valid (fcw_valid),
        .fcw_ready (fcw_ready),
        .phase_clr (phase_clr),
        .phi       (phi),
        .phi_valid (phi_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = 0; m_active = 0; m_pend = 0; m_busy = 0;
        m_phi = 0; m_pv = 0; m_wrap = 0; m_lfsr = 16'hACE1;
    endtask

    // Drive one cycle from a negedge, advance the model, return at the next negedge.
    task automatic step(input bit se, input bit clr, input bit fv, input logic [31:0] data);
        logic [32:0] sum;
        logic [31:0] d;
        bit          xfer;
        sample_en = se; phase_clr = clr; fcw_valid = fv; fcw_data = data;
        xfer = fv && !m_busy;
        if (se) begin
            if (clr) begin
                m_acc = 0; m_wrap = 0;
            end else begin
                sum    = {1'b0, m_acc} + {1'b0, m_active};
                m_wrap = sum[32];
                m_acc  = sum[31:0];
            end
`ifdef NCO_PHASE_DITHER_EN
            d     = 32'(m_lfsr) % (32'd1 << (AW - PW));
            m_phi = clr ? 8'h00 : 8'((m_acc + d) >> (AW - PW));
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
            d     = 0;
            m_phi = 8'((m_acc + d) >> (AW - PW));
`endif
            m_pv = 1;
            if (m_busy) begin
                m_active = m_pend; m_busy = 0;
            end
        end else begin
            m_pv = 0; m_wrap = 0;
        end
        if (xfer) begin
            m_pend = data; m_busy = 1;
        end
        @(posedge clk);
        @(negedge clk);
        sample_en = 0; phase_clr = 0; fcw_valid = 0; fcw_data = '0;
    endtask

    task automatic test_reset();
        rst = 1; sample_en = 0; phase_clr = 0; fcw_valid = 0; fcw_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (fcw_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", fcw_ready); end
        checks++;
        if ({phi, phi_valid, wrap} !== 10'd0) begin
            errors++; $display("FAIL reset_outs: phi=%h pv=%b wrap=%b want zeros", phi, phi_valid, wrap);
        end
        rst = 0;
        #1;
        checks++;
        if (fcw_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", fcw_ready); end
        @(negedge clk);
    endtask

    task automatic test_ramp();
        int wraps = 0;
        step(0, 0, 1, 32'h0100_0000);
        step(1, 0, 0, 0);
        checks++;
        if (phi !== 8'h00) begin errors++; $display("FAIL ramp_activate: phi=%h want 00", phi); end
        for (int k = 1; k <= 257; k++) begin
            step(1, 0, 0, 0);
            if (wrap === 1'b1) wraps++;
            checks++;
            if (phi !== 8'(k % 256) || phi_valid !== 1'b1 || wrap !== (k == 256)) begin
                errors++;
                $display("FAIL ramp_step%0d: phi=%h pv=%b wrap=%b want %h 1 %b", k, phi, phi_valid, wrap, 8'(k % 256), (k == 256));
            end
        end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL ramp_wraps: got %0d want 1", wraps); end
    endtask

    task automatic test_half();
        step(1, 1, 1, 32'h8000_0000);
        step(1, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 0, 0);
            checks++;
            if (phi !== ((k % 2) ? 8'h80 : 8'h00) || wrap !== !(k % 2)) begin
                errors++;
                $display("FAIL half_step%0d: phi=%h wrap=%b want %h %b", k, phi, wrap, (k % 2) ? 8'h80 : 8'h00, !(k % 2));
            end
        end
    endtask

    task automatic test_busy();
        step(1, 1, 0, 0);
        checks++;
        if (fcw_ready !== 1'b1) begin errors++; $display("FAIL busy_idle_ready: got %b want 1", fcw_ready); end
        step(0, 0, 1, 32'h1000_0000);
        checks++;
        if (fcw_ready !== 1'b0) begin errors++; $display("FAIL busy_pend_ready: got %b want 0", fcw_ready); end
        step(0, 0, 1, 32'h2000_0000);
        step(1, 0, 0, 0);
        checks++;
        if (phi !== 8'h80) begin errors++; $display("FAIL busy_old_fcw: phi=%h want 80", phi); end
        step(1, 0, 0, 0);
        checks++;
        if (phi !== 8'h90) begin errors++; $display("FAIL busy_a_applied: phi=%h want 90", phi); end
        checks++;
        if (fcw_ready !== 1'b1) begin errors++; $display("FAIL busy_back_idle: got %b want 1", fcw_ready); end
        step(0, 0, 1, 32'h2000_0000);
        checks++;
        if (fcw_ready !== 1'b0) begin errors++; $display("FAIL busy_b_accepted: ready=%b want 0", fcw_ready); end
    endtask

    task automatic test_same_cycle();
        step(1, 1, 0, 0);
        step(1, 0, 1, 32'h0400_0000);
        checks++;
        if (phi !== 8'h20) begin errors++; $display("FAIL same_old1: phi=%h want 20", phi); end
        step(1, 0, 0, 0);
        checks++;
        if (phi !== 8'h40) begin errors++; $display("FAIL same_old2: phi=%h want 40", phi); end
        step(1, 0, 0, 0);
        checks++;
        if (phi !== 8'h44) begin errors++; $display("FAIL same_new: phi=%h want 44", phi); end
    endtask

    task automatic test_clr_reset();
        step(1, 1, 1, 32'h5A00_0000);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (phi !== 8'h5A) begin errors++; $display("FAIL clr_setup: phi=%h want 5a", phi); end
        step(1, 1, 0, 0);
        checks++;
        if (phi !== 8'h00 || wrap !== 1'b0 || phi_valid !== 1'b1) begin
            errors++; $display("FAIL clr_apply: phi=%h wrap=%b pv=%b want 00 0 1", phi, wrap, phi_valid);
        end
        step(0, 0, 1, 32'h1111_1111);
        step(1, 0, 0, 0);
        rst = 1;
        #1;
        checks++;
        if ({phi, phi_valid, wrap, fcw_ready} !== 11'd0) begin
            errors++; $display("FAIL rst_async: phi=%h pv=%b wrap=%b rdy=%b want zeros", phi, phi_valid, wrap, fcw_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (fcw_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_ready: got %b want 0", fcw_ready); end
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (fcw_ready !== 1'b1) begin errors++; $display("FAIL rst_idle: ready=%b want 1", fcw_ready); end
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (phi !== 8'h00 || wrap !== 1'b0) begin
            errors++; $display("FAIL rst_discard: phi=%h wrap=%b want 00 0", phi, wrap);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1, $urandom);
        for (int k = 0; k < 200; k++) begin
            step(1, 0, 0, 0);
            checks++;
            if (phi !== m_phi || phi_valid !== m_pv || wrap !== m_wrap) begin
                errors++;
                $display("FAIL b2b_%0d: phi=%h pv=%b wrap=%b want %h %b %b", k, phi, phi_valid, wrap, m_phi, m_pv, m_wrap);
            end
        end
    endtask

    task automatic test_random();
        bit se, clr, fv;
        for (int k = 0; k < 1500; k++) begin
            se  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            fv  = ($urandom_range(0, 2) == 0);
            checks++;
            if (fcw_ready !== !m_busy) begin
                errors++; $display("FAIL rnd_ready_%0d: got %b want %b", k, fcw_ready, !m_busy);
            end
            step(se, clr, fv, $urandom);
            checks++;
            if (phi !== m_phi || phi_valid !== m_pv || wrap !== m_wrap) begin
                errors++;
                $display("FAIL rnd_%0d: phi=%h pv=%b wrap=%b want %h %b %b", k, phi, phi_valid, wrap, m_phi, m_pv, m_wrap);
            end
        end
    endtask

`ifdef NCO_PHASE_DITHER_EN
    task automatic test_dither();
        rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        for (int k = 0; k < 1000; k++) begin
            step(1, 0, 0, 0);
            checks++;
            if (dut.lfsr_q !== m_lfsr || dut.acc_q !== 32'd0 || phi > 8'h01 || phi !== m_phi) begin
                errors++;
                $display("FAIL dither_%0d: lfsr=%h acc=%h phi=%h want %h 0 %h", k, dut.lfsr_q, dut.acc_q, phi, m_lfsr, m_phi);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_half();
        test_busy();
        test_same_cycle();
        test_clr_reset();
        test_back_to_back();
        test_random();
`ifdef NCO_PHASE_DITHER_EN
        test_dither();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
